// File: rtl/out_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : out_bus_arbiter
// Description : Round-robin arbiter granting one of four requesters a bounded
//               burst on a shared registered output bus; counts grants.
//               Define OUT_INVERT_EN to drive inverted grantee data on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module out_bus_arbiter #(
    parameter int DW   = 8,
    parameter int HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req_i,
    input  logic [4*DW-1:0] data_in_i,
    output logic [3:0]      gnt_o,
    output logic [1:0]      owner_o,
    output logic [DW-1:0]   bus_out_o,
    output logic            bus_valid_o,
    output logic [7:0]      gnt_cnt_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] c_reload = 4'(HOLD - 1);

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      owner_q, owner_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [3:0]      burst_q, burst_d;
    logic [7:0]      gnt_cnt_q, gnt_cnt_d;
    logic [DW-1:0]   bus_out_q, bus_out_d;
    logic            bus_valid_q, bus_valid_d;

    logic [1:0]      w_search_ptr;
    logic [1:0]      w_win;
    logic            w_any;
    logic            w_end;
    logic [DW-1:0]   w_sel_data;

    // At grant end the pointer moves past the owner, so the search must already
    // start there to give the current owner lowest priority for the handoff.
    assign w_search_ptr = (state_q == GRANT) ? owner_q + 2'd1 : ptr_q;
    assign w_any        = |req_i;
    assign w_end        = !req_i[owner_q] || (burst_q == 4'd0);
    assign w_sel_data   = data_in_i[owner_q*DW +: DW];

    always_comb begin
        w_win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[w_search_ptr + 2'(i)]) begin
                w_win = w_search_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        burst_d   = burst_q;
        gnt_cnt_d = gnt_cnt_q;

        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d   = GRANT;
                    owner_d   = w_win;
                    gnt_d     = 4'b0001 << w_win;
                    burst_d   = c_reload;
                    gnt_cnt_d = gnt_cnt_q + 8'd1;
                end
            end
            GRANT: begin
                if (w_end) begin
                    ptr_d = owner_q + 2'd1;
                    if (w_any) begin
                        owner_d   = w_win;
                        gnt_d     = 4'b0001 << w_win;
                        burst_d   = c_reload;
                        gnt_cnt_d = gnt_cnt_q + 8'd1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else begin
                    burst_d = burst_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        bus_valid_d = (gnt_q != 4'b0000);
        if (gnt_q != 4'b0000) begin
`ifdef OUT_INVERT_EN
            bus_out_d = ~w_sel_data;
`else
            bus_out_d = w_sel_data;
`endif
        end else begin
            bus_out_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            gnt_q       <= 4'b0000;
            burst_q     <= 4'd0;
            gnt_cnt_q   <= 8'd0;
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            burst_q     <= burst_d;
            gnt_cnt_q   <= gnt_cnt_d;
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign owner_o     = owner_q;
    assign bus_out_o   = bus_out_q;
    assign bus_valid_o = bus_valid_q;
    assign gnt_cnt_o   = gnt_cnt_q;

endmodule
`default_nettype wire

// File: doc/out_bus_arbiter.md
# out_bus_arbiter

Round-robin arbiter sharing one 8-bit output bus among four requesters inside a Tiny Tapeout user design. Sits between the internal function blocks (inverter path, pattern generators, etc.) and the `uo_out` pins. Grants one requester at a time for a bounded burst, registers the selected byte onto the bus and counts issued grants.

## Interface
- `DW`, 8, data width per requester and of the bus
- `HOLD`, 4, maximum grant length in cycles, legal range 1..16
- `clk`  input  1  clock, all state on rising edge
- `rst_n`  input  1  reset, asynchronous, active-low
- `req`  input  4  request per requester, level-sensitive
- `data_in`  input  4*DW  requester data; requester i occupies `[i*DW +: DW]`
- `gnt`  output  4  one-hot grant, registered
- `owner`  output  2  index of current grantee, valid while `gnt != 0`
- `bus_out`  output  DW  registered bus data
- `bus_valid`  output  1  registered, high when `bus_out` carries grantee data
- `gnt_cnt`  output  8  number of grants issued, wraps

## Operation
- FSM states: IDLE, GRANT.
- Round-robin pointer `ptr` (2 bits) is the highest-priority index. Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: if `req != 0` → GRANT, winner = first set `req` in search order, `gnt` = onehot(winner), `owner` = winner, burst counter = HOLD-1, `gnt_cnt` += 1.
- GRANT, each edge; grant ends when `req[owner] == 0` or burst counter == 0, else burst counter decrements.
- On grant end: `ptr` = owner+1. If any `req` set (search from the new ptr, so owner is checked last) → direct handoff to the winner in the same edge, no idle cycle, counter reloaded, `gnt_cnt` += 1. Otherwise → IDLE, `gnt` = 0.
- Sole requester still high at expiry is re-granted immediately; that counts as a new grant.
- `gnt_cnt` wraps 255 → 0.
- Bus path: each edge, `bus_valid` <= (`gnt != 0`); `bus_out` <= `data_in[owner]` when `gnt != 0`, else 8'h00.
- `gnt` is always one-hot or zero; never two bits set.

## Timing
- Reset values: `gnt` = 0, `owner` = 0, `bus_out` = 8'h00, `bus_valid` = 0, `gnt_cnt` = 0, `ptr` = 0, state IDLE.
- `req` sampled at edge k → `gnt` high after edge k (visible in cycle k+1).
- `data_in[owner]` in cycle of grant appears on `bus_out` one cycle later; `bus_valid` lags `gnt` by exactly one cycle, including on fall.
- Burst length with `req` held: exactly HOLD cycles of `gnt`. HOLD=1: every grant one cycle; with multiple holders, rotates every cycle.
- Requester dropping `req` in cycle c: it still holds `gnt` in cycle c; loss of `gnt` is visible from cycle c+1.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronously); no partial burst resumes after release. First grant after reset follows pointer 0.

## Configuration
- `OUT_INVERT_EN`: when defined, `bus_out` <= ~`data_in[owner]` during grant (the bus carries inverted data, matching the inverting pin path); idle value remains 8'h00. When undefined, data passes uninverted. No other behaviour changes.

## Test plan
- Reset: assert `rst_n`=0 mid-burst with `req`=4'b0001 → `gnt`=0, `bus_valid`=0, `bus_out`=8'h00, `gnt_cnt`=0 immediately; after release, grant to requester 0 one cycle later.
- Single requester: `req`=4'b0100 held, `data_in[2]`=8'hA5, HOLD=4 → `gnt`=4'b0100 continuously, `gnt_cnt` +1 every 4 cycles, `bus_out`=8'hA5 (8'h5A with `OUT_INVERT_EN`) one cycle after `gnt`.
- Rotation: `req`=4'b1111 held, HOLD=4 → grants in order 0,1,2,3,0 each 4 cycles, no gap cycles, `gnt_cnt`=5 after 20 cycles.
- Early release: requester 1 granted, drops `req` after 2 cycles, `req[3]` high → `gnt` moves 4'b0010 → 4'b1000 at next edge; `bus_valid` stays high through handoff.
- HOLD=1 with `req`=4'b0101 → `gnt` alternates 4'b0001/4'b0100 every cycle.
- Counter wrap: 256 single-cycle grants → `gnt_cnt` returns to 0.
